dcache_port_arbiter: RTL

Arbitrates the single data-cache/memory port between the memory stage's two load ports and the LSQ store-commit port. Load misses (`data_missed1/2`) and retiring stores each raise a held request. The block serialises them into one blocking transaction at a time, then returns load data on the `data_ready`/`data_response` pair that the memory stage consumes. It sits between the memory stage / LSQ and the data cache.

---
 rtl/dcache_port_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Serialises the two memory-stage load-miss ports and the LSQ store-commit
// port onto the single data-cache port, one blocking transaction at a time.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction; arbitrate and latch a winner
// ISSUE | mem_req_valid high with latched fields until mem_req_ready
// WAIT  | request accepted; waiting for mem_resp_valid
// RESP  | one-cycle completion pulse to the owner (unless killed)
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ld1_req/ld1_addr                load port 1 held request + address
//   ld2_req/ld2_addr                load port 2 held request + address
//   st_req/st_addr/st_data          store-commit held request
//   flush                           kills pending load returns
//   data_ready1/data_response1      load 1 completion pulse + held data
//   data_ready2/data_response2      load 2 completion pulse + held data
//   st_done                         store completion pulse
//   busy                            state != IDLE
//   mem_req_*                       downstream request channel
//   mem_resp_valid/mem_resp_data    downstream completion

module dcache_port_arbiter #(
    parameter int ADDR_W        = 64,
    parameter int DATA_W        = 64,
    parameter int MAX_STORE_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld1_req,
    input  logic [ADDR_W-1:0] ld1_addr,
    input  logic              ld2_req,
    input  logic [ADDR_W-1:0] ld2_addr,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic              flush,
    output logic              data_ready1,
    output logic [DATA_W-1:0] data_response1,
    output logic              data_ready2,
    output logic [DATA_W-1:0] data_response2,
    output logic              st_done,
    output logic              busy,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] ID_LD1 = 2'd0;
    localparam logic [1:0] ID_LD2 = 2'd1;
    localparam logic [1:0] ID_ST  = 2'd2;

    localparam int RUN_W = $clog2(MAX_STORE_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STORE_RUN);

    logic [1:0]        state_q, state_d;
    logic [1:0]        id_q, id_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              kill_q, kill_d;
    logic              last_ld2_q, last_ld2_d;   // 1: last load grant went to LD2
    logic [RUN_W-1:0]  run_q, run_d;
    logic [DATA_W-1:0] resp1_q, resp1_d;
    logic [DATA_W-1:0] resp2_q, resp2_d;

    logic ld_any;
    logic st_win;
    logic pick_ld2;
    logic owner_req;

    assign ld_any    = ld1_req | ld2_req;
    assign st_win    = st_req & ((run_q < RUN_MAX) | ~ld_any);
    // On a tie LD2 wins only if LD1 had the previous load grant.
    assign pick_ld2  = ld2_req & (~ld1_req | ~last_ld2_q);
    assign owner_req = (id_q == ID_LD2) ? ld2_req : ld1_req;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        write_d    = write_q;
        addr_d     = addr_q;
        data_d     = data_q;
        kill_d     = kill_q;
        last_ld2_d = last_ld2_q;
        run_d      = run_q;
        resp1_d    = resp1_q;
        resp2_d    = resp2_q;

        // A latched load is killed by flush or by its owner withdrawing while
        // the downstream transaction is in flight.
        if ((state_q != S_IDLE) && !write_q &&
            (flush || ((state_q == S_WAIT) && !owner_req))) begin
            kill_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!flush && (st_req || ld_any)) begin
                    state_d = S_ISSUE;
                    kill_d  = 1'b0;
                    if (st_win) begin
                        id_d    = ID_ST;
                        write_d = 1'b1;
                        addr_d  = st_addr;
                        data_d  = st_data;
                        if (!ld_any) begin
                            run_d = '0;
                        end else if (run_q < RUN_MAX) begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        write_d = 1'b0;
                        data_d  = '0;
                        run_d   = '0;
                        if (pick_ld2) begin
                            id_d       = ID_LD2;
                            addr_d     = ld2_addr;
                            last_ld2_d = 1'b1;
                        end else begin
                            id_d       = ID_LD1;
                            addr_d     = ld1_addr;
                            last_ld2_d = 1'b0;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_RESP;
                    // Killed returns leave the held response untouched.
                    if (!write_q && !kill_d) begin
                        if (id_q == ID_LD1) begin
                            resp1_d = mem_resp_data;
                        end else if (id_q == ID_LD2) begin
                            resp2_d = mem_resp_data;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            id_q       <= ID_LD1;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            kill_q     <= 1'b0;
            last_ld2_q <= 1'b1;
            run_q      <= '0;
            resp1_q    <= '0;
            resp2_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            kill_q     <= kill_d;
            last_ld2_q <= last_ld2_d;
            run_q      <= run_d;
            resp1_q    <= resp1_d;
            resp2_q    <= resp2_d;
        end
    end

    logic in_resp;
    logic ld_ok;

    assign in_resp = (state_q == S_RESP);
    // flush in RESP suppresses the pulse in the same cycle.
    assign ld_ok   = in_resp && !kill_q && !flush;

    assign data_ready1    = ld_ok && (id_q == ID_LD1);
    assign data_ready2    = ld_ok && (id_q == ID_LD2);
    assign st_done        = in_resp && (id_q == ID_ST);
    assign data_response1 = resp1_q;
    assign data_response2 = resp2_q;
    assign busy           = (state_q != S_IDLE);
    assign mem_req_valid  = (state_q == S_ISSUE);
    assign mem_req_write  = write_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_data   = data_q;

endmodule
